// File: rtl/img_pkg.sv
// Shared definitions for the 3x3 pixel window generator: default image size
// and the frame-sequencing FSM states.
package img_pkg;

    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 32;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/line_buf.sv
// One image row of pixel storage: one write port, one read port, and a read
// result registered on the clock edge.
module line_buf #(
    parameter  int DEPTH = 256,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage arrays get no reset; a reset loop over every word would stop
    // this mapping onto RAM, and stale contents are masked downstream anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pixel_window_gen.sv
// Raster-to-3x3 window generator: two line buffers plus a 3x3 shift window,
// out-of-image taps forced to zero, one registered output stage.
module pixel_window_gen
    import img_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] w1,
    output logic [7:0] w2,
    output logic [7:0] w3,
    output logic [7:0] w4,
    output logic [7:0] w5,
    output logic [7:0] w6,
    output logic [7:0] w7,
    output logic [7:0] w8,
    output logic [7:0] w9,
    output logic       m_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    state_t        state, state_d;
    logic          s_fire, out_free, frame_done, flush_step, shift_en, load;
    logic [CW-1:0] in_col, in_col_d, out_col, rd_addr;
    logic [RW-1:0] in_row, in_row_d, out_row;
    logic [7:0]    lb1_q, lb2_q;
    logic [7:0]    win   [3][3];
    logic [7:0]    win_d [3][3];
    logic [7:0]    win_m [3][3];
    logic [7:0]    w_q   [9];

    assign out_free   = !m_valid || m_ready;
    assign s_ready    = (state == ST_FILL) || ((state == ST_RUN) && out_free);
    assign s_fire     = s_valid && s_ready;
    assign frame_done = (state == ST_FLUSH) && m_valid && m_last && m_ready;
    assign flush_step = (state == ST_FLUSH) && out_free && !(m_valid && m_last);
    assign shift_en   = s_fire || flush_step;
    assign load       = (s_fire && (state == ST_RUN)) || flush_step;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        case (state)
            ST_FILL:  if (s_fire && in_row == ROW_ONE && in_col == '0) state_d = ST_RUN;
            ST_RUN:   if (s_fire && in_row == ROW_LAST && in_col == COL_LAST) state_d = ST_FLUSH;
            ST_FLUSH: if (frame_done) state_d = ST_FILL;
            default:  state_d = ST_FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_FILL;
        else        state <= state_d;
    end

    // During FLUSH the input column keeps stepping through a virtual row so
    // the line buffers keep delivering the last two real rows.
    always_comb begin
        in_col_d = in_col;
        in_row_d = in_row;
        if (shift_en) begin
            in_col_d = (in_col == COL_LAST) ? '0 : in_col + 1'b1;
            if (s_fire && in_col == COL_LAST) begin
                in_row_d = (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
            end
        end
        if (frame_done) in_col_d = '0;
    end

    // Reading the next column address gives a zero-latency hit on the next pixel.
    assign rd_addr = rst_n ? in_col_d : '0;

    line_buf #(.DEPTH(IMG_W), .WIDTH(8)) u_lb1 (
        .clk(clk), .wr_en(s_fire), .wr_addr(in_col), .wr_data(s_data),
        .rd_addr(rd_addr), .rd_data(lb1_q)
    );

    line_buf #(.DEPTH(IMG_W), .WIDTH(8)) u_lb2 (
        .clk(clk), .wr_en(s_fire), .wr_addr(in_col), .wr_data(lb1_q),
        .rd_addr(rd_addr), .rd_data(lb2_q)
    );

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win[r][1];
            win_d[r][1] = win[r][2];
        end
        win_d[0][2] = lb2_q;
        win_d[1][2] = lb1_q;
        win_d[2][2] = (state == ST_FLUSH) ? 8'd0 : s_data;
        // Edge masking keys off the output centre, so wrapped-in columns vanish.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if ((r == 0 && out_row == '0) || (r == 2 && out_row == ROW_LAST) ||
                    (c == 0 && out_col == '0) || (c == 2 && out_col == COL_LAST))
                    win_m[r][c] = 8'd0;
                else
                    win_m[r][c] = win_d[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) win[r][c] <= win_d[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_col  <= '0;
            in_row  <= '0;
            out_col <= '0;
            out_row <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            for (int i = 0; i < 9; i++) w_q[i] <= 8'd0;
        end else begin
            in_col <= in_col_d;
            in_row <= in_row_d;
            if (load) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) w_q[r*3 + c] <= win_m[r][c];
                end
                m_valid <= 1'b1;
                m_last  <= (out_row == ROW_LAST) && (out_col == COL_LAST);
                out_col <= (out_col == COL_LAST) ? '0 : out_col + 1'b1;
                if (out_col == COL_LAST) begin
                    out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

    assign w1 = w_q[0];
    assign w2 = w_q[1];
    assign w3 = w_q[2];
    assign w4 = w_q[3];
    assign w5 = w_q[4];
    assign w6 = w_q[5];
    assign w7 = w_q[6];
    assign w8 = w_q[7];
    assign w9 = w_q[8];

endmodule
